dcsk_demod_frame: RTL and testbench
===================================

Name: dcsk_demod_frame

Overview:
- Parameterised DCSK receive demodulator with its own control FSM. Replaces the split datapath/FSM pair.
- Accepts a serial chip stream with valid/ready. For each symbol it captures SF reference chips, then correlates the next SF data chips against them and makes a majority decision.
- Packs FRAME_BITS decided bits into a word and presents it through a one-entry output buffer with valid/ready handshake.
- Sits between the chip-sampling front end and the frame/deframing logic.

Parameters:
- MAX_SF, 16: largest spread factor. Power of two, at least 4.
- FRAME_BITS, 16: decided bits per output word. At least 1.
- SEL_W, $clog2($clog2(MAX_SF)): width of the spread-factor select. Derived; do not override.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- N_Rst  in  1  reset, asynchronous, active-low.
- Sync_Clr  in  1  synchronous abort: discards the partial frame and returns to REF.
- Spread_Factor_Sel  in  SEL_W  SF = 2 << Sel. Sel values above log2(MAX_SF)-1 clamp to MAX_SF.
- In_Chip  in  1  modulated chip.
- In_Valid  in  1  In_Chip is valid.
- In_Ready  out  1  block accepts a chip this cycle.
- Out_Data  out  FRAME_BITS  demodulated word; bit 0 is the first decided bit.
- Out_Valid  out  1  Out_Data and Out_Tie are valid.
- Out_Ready  in  1  consumer accepts the word.
- Out_Tie  out  1  at least one symbol in this word resolved by tie rule.
- Spread_Factor  out  $clog2(MAX_SF)+1  currently latched SF.

Behaviour:
- Chip acceptance: a chip is accepted on a cycle where In_Valid && In_Ready. No other cycle changes chip or accumulator state.
- Reset (N_Rst low): state REF; all counters 0; reference buffer 0; In_Ready=1; Out_Valid=0; Out_Data=0; Out_Tie=0; Spread_Factor = SF for Sel=0, i.e. 2. Reset mid-frame discards everything.
- SF latch: Sel is latched into Spread_Factor only on the first chip accepted in REF of bit 0 of a frame. Sel changes mid-frame take effect at the next frame.
- Counters:
  - chip_idx, $clog2(MAX_SF) bits.
  - bit_idx, $clog2(FRAME_BITS+1) bits.
  - mis_cnt, $clog2(MAX_SF)+1 bits, counting 0..SF.
- State REF:
  - Each accepted chip is written to ref_buf[chip_idx], then chip_idx increments.
  - When chip_idx = SF-1: chip_idx←0, go to DATA.
- State DATA:
  - Each accepted chip computes m = In_Chip ^ ref_buf[chip_idx]; mis_cnt accumulates m.
  - On the last data chip (chip_idx = SF-1), the decision uses the total including the current chip: bit = 1 if total mismatches > SF/2, bit = 0 if fewer.
  - Tie (total = SF/2): bit = 0 and the frame tie flag is set.
  - The decided bit is written to asm[bit_idx] on that edge. mis_cnt←0, chip_idx←0.
  - If bit_idx ≠ FRAME_BITS-1: bit_idx++ and go to REF.
  - Otherwise the frame is complete:
    - If the output buffer is empty, or Out_Ready is high this cycle, load Out_Data←asm and Out_Tie←tie flag, set Out_Valid=1, clear asm, tie flag and bit_idx, and go to REF.
    - Otherwise go to HOLD.
- State HOLD:
  - In_Ready=0.
  - When Out_Ready is high: load the buffer from asm, as above, on that edge, and go to REF.
  - Zero-bubble: In_Ready returns to 1 in the cycle after the transfer.
- In_Ready = 1 in REF and DATA; 0 in HOLD only.
- Output handshake:
  - Out_Valid drops on Out_Ready && Out_Valid unless a new word loads on the same edge, in which case it stays 1 with new data.
  - Out_Data and Out_Tie remain stable while Out_Valid && !Out_Ready.
- Sync_Clr:
  - Priority over chip acceptance. The chip on the same cycle is ignored.
  - Clears chip_idx, bit_idx, mis_cnt, asm and the tie flag; goes to REF.
  - Does not touch the output buffer, so a pending word is still delivered.
  - A frame held in HOLD is discarded.
- Latency: the word is valid on the cycle after the edge that accepted the final data chip of the frame. Zero added cycles if the buffer is free.
- Throughput: one chip per clock, sustained.
- Not allowed: Out_Valid toggling without a handshake; any X on outputs after reset.

Test Plan:
- Sel=0 (SF=2), FRAME_BITS=16; symbols [ref 10, data 01] ×16 → after 64 accepted chips, Out_Valid=1, Out_Data=16'hFFFF, Out_Tie=0, Spread_Factor=2.
- Sel=3 (SF=16):
  - data = ref with 3 chips flipped → bit 0.
  - data = ~ref with 3 chips restored → bit 1.
  - alternate the two for a frame → Out_Data=16'hAAAA.
- Tie at SF=4: data differs from ref in exactly 2 chips for bit 5, all others identical → Out_Data=16'h0000, Out_Tie=1. Next frame has no ties → Out_Tie=0.
- Backpressure:
  - Hold Out_Ready=0 while two frames stream in; second frame completes → HOLD, In_Ready=0, Out_Data unchanged.
  - Assert Out_Ready for one cycle → second word loads on that edge and Out_Valid stays 1.
  - In_Ready=1 the next cycle.
- Sync_Clr on bit 7, mid-DATA, while the prior word is still pending → pending word still delivered intact. The new frame starts fresh; a Sel change applied before Sync_Clr is latched.
- N_Rst pulsed low mid-DATA with Out_Valid=1 → all outputs immediately at reset values (Out_Valid=0, Spread_Factor=2). A full frame afterwards demodulates correctly.

Source files
------------

// File: rtl/dcsk_demod_frame.sv
// DCSK receive demodulator: captures SF reference chips per symbol, correlates the
// following SF data chips by majority vote, and packs FRAME_BITS decisions into a buffered word.
module dcsk_demod_frame #(
  parameter int MAX_SF     = 16,
  parameter int FRAME_BITS = 16,
  parameter int SEL_W      = $clog2($clog2(MAX_SF))
) (
  input  logic                    Clk,
  input  logic                    N_Rst,
  input  logic                    Sync_Clr,
  input  logic [SEL_W-1:0]        Spread_Factor_Sel,
  input  logic                    In_Chip,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  output logic [FRAME_BITS-1:0]   Out_Data,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic                    Out_Tie,
  output logic [$clog2(MAX_SF):0] Spread_Factor
);

  localparam int LG  = $clog2(MAX_SF);
  localparam int SFW = LG + 1;
  localparam int BW  = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    S_REF  = 2'd0,
    S_DATA = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state, w_state_next;
  logic [LG-1:0]         r_chip_idx;
  logic [BW-1:0]         r_bit_idx;
  logic [SFW-1:0]        r_mis_cnt;
  logic [MAX_SF-1:0]     r_ref_buf;
  logic [FRAME_BITS-1:0] r_asm;
  logic                  r_tie;
  logic [SFW-1:0]        r_sf;
  logic                  r_out_valid;
  logic [FRAME_BITS-1:0] r_out_data;
  logic                  r_out_tie;

  logic                  w_accept, w_latch, w_last_chip, w_last_bit, w_m, w_bit, w_tie;
  logic                  w_load, w_load_hold;
  logic [SFW-1:0]        w_sf, w_total, w_half;
  logic [FRAME_BITS-1:0] w_asm_next, w_load_data;
  logic                  w_load_tie;

  function automatic logic [SFW-1:0] sel_to_sf(input logic [SEL_W-1:0] sel);
    if (int'(sel) > LG - 1) begin
      return SFW'(MAX_SF);
    end else begin
      return SFW'(2) << sel;
    end
  endfunction

  assign In_Ready    = (r_state != S_HOLD);
  assign w_accept    = In_Valid && In_Ready && !Sync_Clr;
  // The first chip of a frame uses the freshly selected SF, not the stale latch.
  assign w_latch     = w_accept && (r_state == S_REF) && (r_chip_idx == LG'(0)) && (r_bit_idx == BW'(0));
  assign w_sf        = w_latch ? sel_to_sf(Spread_Factor_Sel) : r_sf;
  assign w_last_chip = ({1'b0, r_chip_idx} == (w_sf - SFW'(1)));
  assign w_last_bit  = (r_bit_idx == BW'(FRAME_BITS - 1));
  assign w_m         = In_Chip ^ r_ref_buf[r_chip_idx];
  assign w_total     = r_mis_cnt + SFW'(w_m);
  assign w_half      = w_sf >> 1;
  assign w_bit       = (w_total > w_half);
  assign w_tie       = (w_total == w_half);
  assign w_asm_next  = r_asm | (FRAME_BITS'(w_bit) << r_bit_idx);
  assign w_load_data = w_load_hold ? r_asm : w_asm_next;
  assign w_load_tie  = w_load_hold ? r_tie : (r_tie | w_tie);

  // Control state register.
  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) begin
      r_state <= S_REF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output-buffer load decision.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_hold  = 1'b0;
    if (Sync_Clr) begin
      w_state_next = S_REF;
    end else begin
      case (r_state)
        S_REF: begin
          if (w_accept && w_last_chip) begin
            w_state_next = S_DATA;
          end else begin
            w_state_next = S_REF;
          end
        end
        S_DATA: begin
          if (w_accept && w_last_chip) begin
            if (!w_last_bit) begin
              w_state_next = S_REF;
            end else if (!r_out_valid || Out_Ready) begin
              w_load       = 1'b1;
              w_state_next = S_REF;
            end else begin
              w_state_next = S_HOLD;
            end
          end else begin
            w_state_next = S_DATA;
          end
        end
        S_HOLD: begin
          if (Out_Ready) begin
            w_load       = 1'b1;
            w_load_hold  = 1'b1;
            w_state_next = S_REF;
          end else begin
            w_state_next = S_HOLD;
          end
        end
        default: w_state_next = S_REF;
      endcase
    end
  end

  // Chip datapath: reference capture, mismatch accumulation and bit assembly.
  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) begin
      r_chip_idx <= '0;
      r_bit_idx  <= '0;
      r_mis_cnt  <= '0;
      r_ref_buf  <= '0;
      r_asm      <= '0;
      r_tie      <= 1'b0;
      r_sf       <= SFW'(2);
    end else if (Sync_Clr) begin
      r_chip_idx <= '0;
      r_bit_idx  <= '0;
      r_mis_cnt  <= '0;
      r_asm      <= '0;
      r_tie      <= 1'b0;
    end else if (w_accept) begin
      if (w_latch) begin
        r_sf <= w_sf;
      end
      if (r_state == S_REF) begin
        r_ref_buf[r_chip_idx] <= In_Chip;
        r_chip_idx            <= w_last_chip ? LG'(0) : r_chip_idx + LG'(1);
      end else if (!w_last_chip) begin
        r_mis_cnt  <= w_total;
        r_chip_idx <= r_chip_idx + LG'(1);
      end else begin
        r_mis_cnt  <= '0;
        r_chip_idx <= '0;
        if (w_load) begin
          r_asm     <= '0;
          r_tie     <= 1'b0;
          r_bit_idx <= '0;
        end else begin
          r_asm     <= w_asm_next;
          r_tie     <= r_tie | w_tie;
          r_bit_idx <= w_last_bit ? r_bit_idx : r_bit_idx + BW'(1);
        end
      end
    end else if (w_load_hold) begin
      r_asm     <= '0;
      r_tie     <= 1'b0;
      r_bit_idx <= '0;
    end
  end

  // One-entry output buffer.
  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tie   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_data;
      r_out_tie   <= w_load_tie;
    end else if (Out_Ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign Out_Valid     = r_out_valid;
  assign Out_Data      = r_out_data;
  assign Out_Tie       = r_out_tie;
  assign Spread_Factor = r_sf;

endmodule

// File: tb/tb_dcsk_demod_frame.sv
// Directed bench for dcsk_demod_frame: frame table plus backpressure, Sync_Clr and reset sequences.
module tb_dcsk_demod_frame;

  logic        Clk = 1'b0;
  logic        N_Rst;
  logic        Sync_Clr;
  logic [1:0]  Spread_Factor_Sel;
  logic        In_Chip;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] Out_Data;
  logic        Out_Valid;
  logic        Out_Ready;
  logic        Out_Tie;
  logic [4:0]  Spread_Factor;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  dcsk_demod_frame #(.MAX_SF(16), .FRAME_BITS(16)) dut (
    .Clk(Clk), .N_Rst(N_Rst), .Sync_Clr(Sync_Clr), .Spread_Factor_Sel(Spread_Factor_Sel),
    .In_Chip(In_Chip), .In_Valid(In_Valid), .In_Ready(In_Ready), .Out_Data(Out_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Tie(Out_Tie), .Spread_Factor(Spread_Factor)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] rp;
    logic [15:0] mlo;
    logic [15:0] bits;
    int          tie_idx;
    logic [15:0] tmask;
    logic [15:0] exp_data;
    logic        exp_tie;
    logic [4:0]  exp_sf;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the chip was accepted.
  task automatic send_chip(input logic c);
    int n = 0;
    In_Chip  = c;
    In_Valid = 1'b1;
    while (!In_Ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got In_Ready=0 for %0d cycles, expected 1", n);
    end
    @(negedge Clk);
    In_Valid = 1'b0;
  endtask

  task automatic send_sym(input int sf, input logic [15:0] r, input logic [15:0] d);
    for (int i = 0; i < sf; i++) send_chip(r[i]);
    for (int i = 0; i < sf; i++) send_chip(d[i]);
  endtask

  task automatic send_frame(input vec_t v, input bit idle_chk);
    int sf;
    int c0;
    logic [15:0] d;
    sf = 2 << v.sel;
    Spread_Factor_Sel = v.sel;
    c0 = cyc;
    for (int b = 0; b < 16; b++) begin
      if (b == v.tie_idx) d = v.rp ^ v.tmask;
      else if (v.bits[b]) d = v.rp ^ ~v.mlo;
      else d = v.rp ^ v.mlo;
      if (b == 15 && idle_chk) chk("idle_before_last", {31'd0, Out_Valid}, 32'd0);
      send_sym(sf, v.rp, d);
    end
    chk("frame_cycles", cyc - c0, 2 * sf * 16);
  endtask

  vec_t tmp;

  initial begin
    vecs[0] = '{sel: 2'd0, rp: 16'h0001, mlo: 16'h0000, bits: 16'hFFFF, tie_idx: -1, tmask: 16'h0000,
                exp_data: 16'hFFFF, exp_tie: 1'b0, exp_sf: 5'd2};
    vecs[1] = '{sel: 2'd3, rp: 16'hC3A5, mlo: 16'h0111, bits: 16'hAAAA, tie_idx: -1, tmask: 16'h0000,
                exp_data: 16'hAAAA, exp_tie: 1'b0, exp_sf: 5'd16};
    vecs[2] = '{sel: 2'd1, rp: 16'h0009, mlo: 16'h0000, bits: 16'h0000, tie_idx: 5, tmask: 16'h0003,
                exp_data: 16'h0000, exp_tie: 1'b1, exp_sf: 5'd4};
    vecs[3] = '{sel: 2'd1, rp: 16'h0006, mlo: 16'h0001, bits: 16'h5A3C, tie_idx: -1, tmask: 16'h0000,
                exp_data: 16'h5A3C, exp_tie: 1'b0, exp_sf: 5'd4};
    vecs[4] = '{sel: 2'd2, rp: 16'h0096, mlo: 16'h0021, bits: 16'h1234, tie_idx: 15, tmask: 16'h000F,
                exp_data: 16'h1234, exp_tie: 1'b1, exp_sf: 5'd8};

    N_Rst = 1'b0; Sync_Clr = 1'b0; Spread_Factor_Sel = 2'd0;
    In_Chip = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
    #12;
    chk("rst_in_ready",  {31'd0, In_Ready},  32'd1);
    chk("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
    chk("rst_out_data",  {16'd0, Out_Data},  32'd0);
    chk("rst_out_tie",   {31'd0, Out_Tie},   32'd0);
    chk("rst_sf",        {27'd0, Spread_Factor}, 32'd2);
    @(negedge Clk);
    N_Rst = 1'b1;

    for (int k = 0; k < 5; k++) begin
      send_frame(vecs[k], 1'b1);
      chk("tbl_valid", {31'd0, Out_Valid}, 32'd1);
      chk("tbl_data",  {16'd0, Out_Data},  {16'd0, vecs[k].exp_data});
      chk("tbl_tie",   {31'd0, Out_Tie},   {31'd0, vecs[k].exp_tie});
      chk("tbl_sf",    {27'd0, Spread_Factor}, {27'd0, vecs[k].exp_sf});
    end
    @(negedge Clk);
    chk("drained", {31'd0, Out_Valid}, 32'd0);

    // Backpressure: two frames with the consumer stalled.
    Out_Ready = 1'b0;
    tmp = '{sel: 2'd1, rp: 16'h000A, mlo: 16'h0000, bits: 16'hF00F, tie_idx: -1, tmask: 16'h0000,
            exp_data: 16'hF00F, exp_tie: 1'b0, exp_sf: 5'd4};
    send_frame(tmp, 1'b0);
    chk("bp_first_valid", {31'd0, Out_Valid}, 32'd1);
    tmp.bits = 16'h0FF0;
    send_frame(tmp, 1'b0);
    chk("bp_hold_in_ready", {31'd0, In_Ready}, 32'd0);
    chk("bp_hold_data", {16'd0, Out_Data}, 32'h0000F00F);
    repeat (3) @(negedge Clk);
    chk("bp_hold_stable", {16'd0, Out_Data}, 32'h0000F00F);
    chk("bp_hold_valid", {31'd0, Out_Valid}, 32'd1);
    Out_Ready = 1'b1;
    @(negedge Clk);
    Out_Ready = 1'b0;
    chk("bp_reload_valid", {31'd0, Out_Valid}, 32'd1);
    chk("bp_reload_data", {16'd0, Out_Data}, 32'h00000FF0);
    chk("bp_in_ready_back", {31'd0, In_Ready}, 32'd1);
    Out_Ready = 1'b1;
    @(negedge Clk);
    chk("bp_drained", {31'd0, Out_Valid}, 32'd0);

    // Sync_Clr mid-DATA of bit 7 with a word still pending.
    Out_Ready = 1'b0;
    tmp = '{sel: 2'd1, rp: 16'h000C, mlo: 16'h0000, bits: 16'h00FF, tie_idx: -1, tmask: 16'h0000,
            exp_data: 16'h00FF, exp_tie: 1'b0, exp_sf: 5'd4};
    send_frame(tmp, 1'b0);
    for (int b = 0; b < 7; b++) send_sym(4, 16'h0005, 16'h000A);
    for (int i = 0; i < 4; i++) send_chip(1'b1);
    send_chip(1'b0);
    send_chip(1'b0);
    Spread_Factor_Sel = 2'd2;
    Sync_Clr = 1'b1; In_Valid = 1'b1; In_Chip = 1'b1;
    @(negedge Clk);
    Sync_Clr = 1'b0; In_Valid = 1'b0;
    chk("clr_pending_valid", {31'd0, Out_Valid}, 32'd1);
    chk("clr_pending_data", {16'd0, Out_Data}, 32'h000000FF);
    chk("clr_sf_unchanged", {27'd0, Spread_Factor}, 32'd4);
    Out_Ready = 1'b1;
    @(negedge Clk);
    chk("clr_delivered", {31'd0, Out_Valid}, 32'd0);
    tmp = '{sel: 2'd2, rp: 16'h003C, mlo: 16'h0001, bits: 16'h8421, tie_idx: -1, tmask: 16'h0000,
            exp_data: 16'h8421, exp_tie: 1'b0, exp_sf: 5'd8};
    send_frame(tmp, 1'b1);
    chk("clr_new_data", {16'd0, Out_Data}, 32'h00008421);
    chk("clr_new_sf", {27'd0, Spread_Factor}, 32'd8);
    @(negedge Clk);

    // Asynchronous reset mid-DATA with a word pending.
    Out_Ready = 1'b0;
    tmp = '{sel: 2'd0, rp: 16'h0002, mlo: 16'h0000, bits: 16'h1111, tie_idx: -1, tmask: 16'h0000,
            exp_data: 16'h1111, exp_tie: 1'b0, exp_sf: 5'd2};
    send_frame(tmp, 1'b0);
    chk("rst2_pending", {16'd0, Out_Data}, 32'h00001111);
    Spread_Factor_Sel = 2'd3;
    for (int b = 0; b < 3; b++) send_sym(16, 16'h00FF, 16'hFF00);
    for (int i = 0; i < 16; i++) send_chip(1'b1);
    send_chip(1'b0);
    N_Rst = 1'b0;
    #1;
    chk("rst2_valid", {31'd0, Out_Valid}, 32'd0);
    chk("rst2_data", {16'd0, Out_Data}, 32'd0);
    chk("rst2_sf", {27'd0, Spread_Factor}, 32'd2);
    chk("rst2_in_ready", {31'd0, In_Ready}, 32'd1);
    @(negedge Clk);
    N_Rst = 1'b1;
    Out_Ready = 1'b1;
    tmp = '{sel: 2'd3, rp: 16'h5AF0, mlo: 16'h8001, bits: 16'hBEEF, tie_idx: -1, tmask: 16'h0000,
            exp_data: 16'hBEEF, exp_tie: 1'b0, exp_sf: 5'd16};
    send_frame(tmp, 1'b1);
    chk("rst2_frame_valid", {31'd0, Out_Valid}, 32'd1);
    chk("rst2_frame_data", {16'd0, Out_Data}, 32'h0000BEEF);
    chk("rst2_frame_tie", {31'd0, Out_Tie}, 32'd0);
    chk("rst2_frame_sf", {27'd0, Spread_Factor}, 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
